// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command-side controller for a 64-bit combinational ALU.
//
// It owns a small operand register file and accepts one command per valid/ready
// handshake. Operands are read at launch and driven to the ALU as registered R/S/Alu_Op.
// The result Y and flags {C,N,Z,V} are captured, and the result is written back.
// MUL is sequenced as MUL then MSW, and DIV as DIV then REM. The operands are held
// stable across each pair, because the ALU derives MSW/REM from the same operands.
// Divide-by-zero is trapped before write-back. MSW or REM issued on its own is
// rejected as illegal.
//
// Optional build macro:
//   CMD_SKID_EN  adds a one-entry command holding register so that a command can be
//                accepted while the sequencer is busy (cmd_ready = !holding_full).
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid / cmd_ready       command handshake
//   cmd_op, cmd_rs1, cmd_rs2    opcode (ALU encoding) and operand registers
//   cmd_rd, cmd_rd2             destination; second destination (MSW / remainder)
//   host_we, host_addr,
//   host_wdata, host_rdata      host register-file write port, combinational read
//   alu_r, alu_s, alu_op        registered operands/opcode to the ALU
//   alu_y, alu_c/n/z/v          ALU result and flags
//   flags                       {C,N,Z,V} of the last completed command
//   done                        one-cycle completion pulse
//   resp_err                    {illegal, div0}, valid while done=1
module alu_cmd_sequencer #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rs1,
  input  logic [REG_AW-1:0] cmd_rs2,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_rd2,
  input  logic              host_we,
  input  logic [REG_AW-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic [DATA_W-1:0] alu_r,
  output logic [DATA_W-1:0] alu_s,
  output logic [4:0]        alu_op,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_c,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_v,
  output logic [3:0]        flags,
  output logic              done,
  output logic [1:0]        resp_err
);

  localparam int unsigned REG_N = 1 << REG_AW;

  localparam logic [4:0] OP_MUL    = 5'b00010;
  localparam logic [4:0] OP_MSW    = 5'b00011;
  localparam logic [4:0] OP_DIV    = 5'b00100;
  localparam logic [4:0] OP_REM    = 5'b00101;
  localparam logic [4:0] OP_PASS_S = 5'b10100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_EXEC2 = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_rf [REG_N];
  logic [4:0]          r_op;
  logic [REG_AW-1:0]   r_rd;
  logic [REG_AW-1:0]   r_rd2;
  logic [DATA_W-1:0]   r_alu_r;
  logic [DATA_W-1:0]   r_alu_s;
  logic [4:0]          r_alu_op;
  logic [3:0]          r_flags;
  logic                r_done;
  logic [1:0]          r_resp_err;

  logic                w_launch;
  logic [4:0]          w_l_op;
  logic [REG_AW-1:0]   w_l_rs1;
  logic [REG_AW-1:0]   w_l_rs2;
  logic [REG_AW-1:0]   w_l_rd;
  logic [REG_AW-1:0]   w_l_rd2;
  logic                w_div0;
  logic                w_illegal;
  logic [3:0]          w_alu_flags;
  logic                w_seq_we;
  logic [REG_AW-1:0]   w_seq_addr;

  assign alu_r      = r_alu_r;
  assign alu_s      = r_alu_s;
  assign alu_op     = r_alu_op;
  assign flags      = r_flags;
  assign done       = r_done;
  assign resp_err   = r_resp_err;
  assign host_rdata = r_rf[host_addr];

  assign w_alu_flags = {alu_c, alu_n, alu_z, alu_v};
  // The divisor is checked on the held S operand, before any write-back.
  assign w_div0      = (r_op == OP_DIV) && (r_alu_s == '0);
  assign w_illegal   = (r_op == OP_MSW) || (r_op == OP_REM);

`ifdef CMD_SKID_EN
  // One-entry holding register for a command accepted while busy.
  logic              r_sk_full;
  logic [4:0]        r_sk_op;
  logic [REG_AW-1:0] r_sk_rs1;
  logic [REG_AW-1:0] r_sk_rs2;
  logic [REG_AW-1:0] r_sk_rd;
  logic [REG_AW-1:0] r_sk_rd2;

  assign cmd_ready = !r_sk_full;
  assign w_launch  = (r_state == ST_IDLE) && (r_sk_full || cmd_valid);

  // A held command has priority; it launches on the idle cycle after DONE.
  always_comb begin
    w_l_op  = cmd_op;
    w_l_rs1 = cmd_rs1;
    w_l_rs2 = cmd_rs2;
    w_l_rd  = cmd_rd;
    w_l_rd2 = cmd_rd2;
    if (r_sk_full) begin
      w_l_op  = r_sk_op;
      w_l_rs1 = r_sk_rs1;
      w_l_rs2 = r_sk_rs2;
      w_l_rd  = r_sk_rd;
      w_l_rd2 = r_sk_rd2;
    end
  end

  // Capture a command offered while the sequencer is not idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sk_full <= 1'b0;
      r_sk_op   <= '0;
      r_sk_rs1  <= '0;
      r_sk_rs2  <= '0;
      r_sk_rd   <= '0;
      r_sk_rd2  <= '0;
    end else if (r_sk_full) begin
      if (r_state == ST_IDLE) begin
        r_sk_full <= 1'b0;
      end
    end else if (cmd_valid && (r_state != ST_IDLE)) begin
      r_sk_full <= 1'b1;
      r_sk_op   <= cmd_op;
      r_sk_rs1  <= cmd_rs1;
      r_sk_rs2  <= cmd_rs2;
      r_sk_rd   <= cmd_rd;
      r_sk_rd2  <= cmd_rd2;
    end
  end
`else
  // The ready flag mirrors the IDLE state, held in its own flop.
  logic r_cmd_ready;

  assign cmd_ready = r_cmd_ready;
  assign w_launch  = r_cmd_ready && cmd_valid;
  assign w_l_op    = cmd_op;
  assign w_l_rs1   = cmd_rs1;
  assign w_l_rs2   = cmd_rs2;
  assign w_l_rd    = cmd_rd;
  assign w_l_rd2   = cmd_rd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_ready <= 1'b1;
    end else if (w_launch) begin
      r_cmd_ready <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_cmd_ready <= 1'b1;
    end
  end
`endif

  // Sequencer write port: low word/quotient in EXEC, MSW/remainder in EXEC2.
  always_comb begin
    w_seq_we   = 1'b0;
    w_seq_addr = r_rd;
    case (r_state)
      ST_EXEC:  w_seq_we = !w_div0 && !w_illegal;
      ST_EXEC2: begin
        w_seq_we   = 1'b1;
        w_seq_addr = r_rd2;
      end
      default:  w_seq_we = 1'b0;
    endcase
  end

  // Register file. Entry 0 is never written, so it always reads zero.
  // The sequencer write comes last, so it wins an address collision with the host.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      if (host_we && (host_addr != '0)) begin
        r_rf[host_addr] <= host_wdata;
      end
      if (w_seq_we && (w_seq_addr != '0)) begin
        r_rf[w_seq_addr] <= alu_y;
      end
    end
  end

  // Command FSM with registered ALU drive, flags and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_alu_r    <= '0;
      r_alu_s    <= '0;
      r_alu_op   <= OP_PASS_S;
      r_op       <= OP_PASS_S;
      r_rd       <= '0;
      r_rd2      <= '0;
      r_flags    <= '0;
      r_done     <= 1'b0;
      r_resp_err <= '0;
    end else begin
      r_done     <= 1'b0;
      r_resp_err <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_alu_r  <= r_rf[w_l_rs1];
            r_alu_s  <= r_rf[w_l_rs2];
            r_alu_op <= w_l_op;
            r_op     <= w_l_op;
            r_rd     <= w_l_rd;
            r_rd2    <= w_l_rd2;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_div0) begin
            r_flags    <= 4'b0001;
            r_resp_err <= 2'b01;
            r_done     <= 1'b1;
            r_state    <= ST_DONE;
          end else if (w_illegal) begin
            r_resp_err <= 2'b10;
            r_done     <= 1'b1;
            r_state    <= ST_DONE;
          end else begin
            r_flags <= w_alu_flags;
            if (r_op == OP_MUL) begin
              r_alu_op <= OP_MSW;
              r_state  <= ST_EXEC2;
            end else if (r_op == OP_DIV) begin
              r_alu_op <= OP_REM;
              r_state  <= ST_EXEC2;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_EXEC2: begin
          r_flags <= w_alu_flags;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_alu_op <= OP_PASS_S;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: stand-in combinational ALU, directed vector table,
// hand-written corner sequences and randomized commands against a register-file model.
module tb_alu_cmd_sequencer;

  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_MSW  = 5'b00011;
  localparam logic [4:0] OP_DIV  = 5'b00100;
  localparam logic [4:0] OP_REM  = 5'b00101;
  localparam logic [4:0] OP_ADD  = 5'b00110;
  localparam logic [4:0] OP_SUB  = 5'b00111;
  localparam logic [4:0] OP_INC  = 5'b01000;
  localparam logic [4:0] OP_PASS = 5'b10100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_op = '0;
  logic [3:0]  cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0, cmd_rd2 = '0;
  logic        host_we = 1'b0;
  logic [3:0]  host_addr = '0;
  logic [63:0] host_wdata = '0;
  logic [63:0] host_rdata;
  logic [63:0] alu_r, alu_s, alu_y;
  logic [4:0]  alu_op;
  logic        alu_c, alu_n, alu_z, alu_v;
  logic [3:0]  flags;
  logic        done;
  logic [1:0]  resp_err;

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .cmd_rd2(cmd_rd2),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .alu_r(alu_r), .alu_s(alu_s), .alu_op(alu_op), .alu_y(alu_y),
    .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .flags(flags), .done(done), .resp_err(resp_err)
  );

  // Stand-in ALU: returns {C,N,Z,V,Y}. MUL/MSW signed product, DIV/REM unsigned.
  function automatic logic [67:0] alu_eval(input logic [4:0] op, input logic [63:0] r,
                                           input logic [63:0] s);
    logic signed [127:0] rr, ss, pp;
    logic [64:0] t;
    logic [63:0] y;
    logic c, v;
    rr = {{64{r[63]}}, r};
    ss = {{64{s[63]}}, s};
    pp = rr * ss;
    c = 1'b0; v = 1'b0; t = '0;
    case (op)
      OP_MUL: y = pp[63:0];
      OP_MSW: y = pp[127:64];
      OP_DIV: y = (s == 64'd0) ? '1 : r / s;
      OP_REM: y = (s == 64'd0) ? r : r % s;
      OP_ADD: begin
        t = {1'b0, r} + {1'b0, s};
        y = t[63:0]; c = t[64];
        v = (r[63] == s[63]) && (y[63] != r[63]);
      end
      OP_SUB: begin
        t = {1'b0, r} - {1'b0, s};
        y = t[63:0]; c = t[64];
        v = (r[63] != s[63]) && (y[63] != r[63]);
      end
      OP_INC: y = r + 64'd1;
      default: y = s;
    endcase
    return {c, y[63], (y == 64'd0), v, y};
  endfunction

  assign {alu_c, alu_n, alu_z, alu_v, alu_y} = alu_eval(alu_op, alu_r, alu_s);

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] m_rf [16];
  logic [3:0]  m_flags;

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rd2;
    logic [63:0] r1v;
    logic [63:0] r2v;
    logic [63:0] exp_rd;
    logic [63:0] exp_rd2;
    logic [3:0]  exp_fl;
    logic [1:0]  exp_err;
    int          exp_lat;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [63:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(posedge clk); #1;
    host_we = 1'b0;
    if (a != 4'd0) m_rf[a] = d;
  endtask

  task automatic rd_rf(input logic [3:0] a, output logic [63:0] d);
    host_addr = a;
    #1;
    d = host_rdata;
  endtask

  task automatic check_rf_all(input string tag);
    logic [63:0] d;
    int mism, bad;
    mism = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      rd_rf(4'(i), d);
      if (d !== m_rf[i]) begin
        if (mism == 0) bad = i;
        mism++;
      end
    end
    chk($sformatf("%s_rf_first_bad_%0d", tag, bad), 64'(mism), 64'd0);
  endtask

  // Reference: operands read before any same-cycle host write; host write then
  // sequencer writes in program order (sequencer wins collisions, rd2 after rd).
  task automatic ref_cmd(input logic [4:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [3:0] rd, input logic [3:0] rd2, input int hw_phase,
                         input logic [3:0] hw_addr, input logic [63:0] hw_data,
                         output logic [1:0] e_err, output int e_lat);
    logic [63:0] a, b;
    logic [67:0] res;
    a = m_rf[rs1];
    b = m_rf[rs2];
    if (hw_phase != 0 && hw_addr != 4'd0) m_rf[hw_addr] = hw_data;
    e_err = 2'b00;
    e_lat = 2;
    if (op == OP_DIV && b == 64'd0) begin
      m_flags = 4'b0001;
      e_err   = 2'b01;
    end else if (op == OP_MSW || op == OP_REM) begin
      e_err = 2'b10;
    end else begin
      res = alu_eval(op, a, b);
      if (rd != 4'd0) m_rf[rd] = res[63:0];
      m_flags = res[67:64];
      if (op == OP_MUL || op == OP_DIV) begin
        res = alu_eval((op == OP_MUL) ? OP_MSW : OP_REM, a, b);
        if (rd2 != 4'd0) m_rf[rd2] = res[63:0];
        m_flags = res[67:64];
        e_lat = 3;
      end
    end
  endtask

  // Issues one command; hw_phase 1 = host write in the launch cycle, 2 = in EXEC.
  // lat is the cycle (relative to handshake edge T) in which done is high, 0 if never.
  task automatic issue(input logic [4:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic [3:0] rd2, input int hw_phase,
                       input logic [3:0] hw_addr, input logic [63:0] hw_data,
                       output int lat, output logic [1:0] err, output logic [3:0] fl);
    int guard;
    lat = 0; err = '0; fl = '0; guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_rd2 = rd2;
    if (hw_phase == 1) begin
      host_we = 1'b1; host_addr = hw_addr; host_wdata = hw_data;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; host_we = 1'b0;
    @(negedge clk);
    if (hw_phase == 2) begin
      host_we = 1'b1; host_addr = hw_addr; host_wdata = hw_data;
    end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      host_we = 1'b0;
      @(negedge clk);
      if (done) begin
        lat = k + 1; err = resp_err; fl = flags;
        break;
      end
    end
  endtask

  task automatic do_cmd(input string tag, input logic [4:0] op, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [3:0] rd, input logic [3:0] rd2,
                        input int hw_phase, input logic [3:0] hw_addr, input logic [63:0] hw_data);
    logic [1:0] e_err, err;
    logic [3:0] fl;
    int e_lat, lat;
    ref_cmd(op, rs1, rs2, rd, rd2, hw_phase, hw_addr, hw_data, e_err, e_lat);
    issue(op, rs1, rs2, rd, rd2, hw_phase, hw_addr, hw_data, lat, err, fl);
    chk({tag, "_lat"}, 64'(lat), 64'(e_lat));
    chk({tag, "_err"}, 64'(err), 64'(e_err));
    chk({tag, "_flags"}, 64'(fl), 64'(m_flags));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    check_rf_all(tag);
  endtask

  function automatic logic [63:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 64'($urandom_range(0, 20));
      1:       return 64'd0;
      2:       return {$urandom, $urandom};
      default: return 64'd0 - 64'($urandom_range(1, 20));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [63:0] d;
    logic [1:0]  e_err, err;
    logic [3:0]  fl;
    int          e_lat, lat;
    logic [4:0]  op;
    logic [4:0]  ops [8];
    int          ph;

    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_flags = '0;
    ops = '{OP_MUL, OP_MSW, OP_DIV, OP_REM, OP_ADD, OP_SUB, OP_INC, OP_PASS};

    vecs[0] = '{OP_ADD,   4'd3,  4'd3,  64'd5, 64'd7, 64'd12, 64'd12, 4'b0000, 2'b00, 2};
    vecs[1] = '{OP_MUL,   4'd4,  4'd5,  64'hFFFF_FFFF_FFFF_FFFD, 64'd4,
                64'hFFFF_FFFF_FFFF_FFF4, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100, 2'b00, 3};
    vecs[2] = '{OP_DIV,   4'd6,  4'd7,  64'd17, 64'd5, 64'd3, 64'd2, 4'b0000, 2'b00, 3};
    vecs[3] = '{OP_DIV,   4'd6,  4'd7,  64'd17, 64'd0, 64'd3, 64'd2, 4'b0001, 2'b01, 2};
    vecs[4] = '{OP_REM,   4'd8,  4'd8,  64'd17, 64'd5, 64'd0, 64'd0, 4'b0001, 2'b10, 2};
    vecs[5] = '{OP_SUB,   4'd0,  4'd0,  64'd9,  64'd9, 64'd0, 64'd0, 4'b0010, 2'b00, 2};
    vecs[6] = '{OP_ADD,   4'd9,  4'd9,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'b0101, 2'b00, 2};
    vecs[7] = '{5'b11111, 4'd10, 4'd10, 64'd0, 64'h1234, 64'h1234, 64'h1234, 4'b0000, 2'b00, 2};
    vecs[8] = '{OP_MUL,   4'd11, 4'd11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd4,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100, 2'b00, 3};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_alu_op", 64'(alu_op), 64'(OP_PASS));
    chk("rst_alu_r", alu_r, 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    check_rf_all("rst0");

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      host_write(4'd1, vecs[i].r1v);
      host_write(4'd2, vecs[i].r2v);
      ref_cmd(vecs[i].op, 4'd1, 4'd2, vecs[i].rd, vecs[i].rd2, 0, 4'd0, 64'd0, e_err, e_lat);
      issue(vecs[i].op, 4'd1, 4'd2, vecs[i].rd, vecs[i].rd2, 0, 4'd0, 64'd0, lat, err, fl);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
      chk($sformatf("vec%0d_flags", i), 64'(fl), 64'(vecs[i].exp_fl));
      rd_rf(vecs[i].rd, d);
      chk($sformatf("vec%0d_rd", i), d, vecs[i].exp_rd);
      rd_rf(vecs[i].rd2, d);
      chk($sformatf("vec%0d_rd2", i), d, vecs[i].exp_rd2);
    end
    check_rf_all("table");

    // Host write to rs1 in the launch cycle: launch uses the old value
    host_write(4'd1, 64'd100);
    host_write(4'd2, 64'd1);
    do_cmd("launch_hw", OP_ADD, 4'd1, 4'd2, 4'd3, 4'd3, 1, 4'd1, 64'd500);
    rd_rf(4'd3, d);
    chk("launch_hw_r3", d, 64'd101);
    // Host and sequencer write rd in the same cycle: the sequencer wins
    do_cmd("collide", OP_ADD, 4'd1, 4'd2, 4'd3, 4'd3, 2, 4'd3, 64'hDEAD);
    rd_rf(4'd3, d);
    chk("collide_r3", d, 64'd501);
    // Divide-by-zero with a host write to rd in EXEC: nothing overrides the host
    host_write(4'd2, 64'd0);
    do_cmd("div0_hw", OP_DIV, 4'd1, 4'd2, 4'd3, 4'd4, 2, 4'd3, 64'hBEEF);

    // Reset during EXEC2 of a MUL
    host_write(4'd1, 64'hFFFF_FFFF_FFFF_FFFD);
    host_write(4'd2, 64'd4);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_MUL; cmd_rs1 = 4'd1; cmd_rs2 = 4'd2; cmd_rd = 4'd4; cmd_rd2 = 4'd5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_flags", 64'(flags), 64'd0);
    chk("mid_rst_alu_op", 64'(alu_op), 64'(OP_PASS));
    chk("mid_rst_alu_s", alu_s, 64'd0);
    chk("mid_rst_err", 64'(resp_err), 64'd0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_flags = '0;
    check_rf_all("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    host_write(4'd1, 64'd5);
    host_write(4'd2, 64'd7);
    do_cmd("post_rst", OP_ADD, 4'd1, 4'd2, 4'd3, 4'd3, 0, 4'd0, 64'd0);

    // Randomized commands against the model
    for (int n = 0; n < 50; n++) begin
      if ($urandom_range(0, 1) == 1) host_write(4'($urandom_range(1, 15)), rand_val());
      if ($urandom_range(0, 1) == 1) host_write(4'($urandom_range(1, 15)), rand_val());
      op = ops[$urandom_range(0, 7)];
      if (op == OP_PASS) op = 5'($urandom_range(0, 31));
      ph = $urandom_range(0, 3);
      if (ph == 3) ph = 0;
      do_cmd($sformatf("rnd%0d", n), op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ph,
             4'($urandom_range(0, 15)), rand_val());
    end

`ifdef CMD_SKID_EN
    begin : skid_test
      int d1, d2;
      d1 = 0; d2 = 0;
      host_write(4'd1, 64'd10);
      host_write(4'd2, 64'd20);
      ref_cmd(OP_ADD, 4'd1, 4'd2, 4'd3, 4'd3, 0, 4'd0, 64'd0, e_err, e_lat);
      ref_cmd(OP_INC, 4'd3, 4'd0, 4'd4, 4'd4, 0, 4'd0, 64'd0, e_err, e_lat);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rs1 = 4'd1; cmd_rs2 = 4'd2; cmd_rd = 4'd3; cmd_rd2 = 4'd3;
      @(posedge clk); #1;
      cmd_op = OP_INC; cmd_rs1 = 4'd3; cmd_rs2 = 4'd0; cmd_rd = 4'd4; cmd_rd2 = 4'd4;
      @(negedge clk);
      chk("skid_ready_busy", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int k = 2; k <= 10; k++) begin
        @(negedge clk);
        if (done) begin
          if (d1 == 0) d1 = k;
          else if (d2 == 0) d2 = k;
        end
        @(posedge clk); #1;
      end
      chk("skid_done1", 64'(d1), 64'd2);
      chk("skid_done2", 64'(d2), 64'd5);
      rd_rf(4'd4, d);
      chk("skid_r4", d, 64'd31);
      check_rf_all("skid");
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
